detector_scan_ctrl: RTL and testbench

DETECTOR_SCAN_CTRL -- requirements
Module: detector_scan_ctrl

---
 rtl/detector_scan_ctrl_pkg.sv | 15 +
 rtl/detector_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_detector_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/detector_scan_ctrl_pkg.sv
// Shared definitions for detector_scan_ctrl: 2-bit FSM state encodings and
// default word / match-count widths.
package detector_scan_ctrl_pkg;

  localparam int W_DEFAULT  = 16;
  localparam int CW_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_REPORT = 2'd3
  } scan_state_t;

endpackage

// File: rtl/detector_scan_ctrl.sv
// detector_scan_ctrl: accepts a W-bit word, serialises it MSB first into an
// external sequence detector and counts the detector's Mealy matches.
// Optional build macro SCAN_CONTINUE_EN: skip the CLEAR state and keep the
// detector state across words so matches may span word boundaries.
module detector_scan_ctrl
  import detector_scan_ctrl_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          det_en,
  output logic          det_a,
  output logic          det_clr,
  input  logic          det_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  scan_state_t   r_state;
  scan_state_t   w_state_next;
  logic [W-1:0]  r_shift;
  logic [IW-1:0] r_bit_idx;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_out_count;
  logic [CW-1:0] w_count_step;
  logic          w_accept;
  logic          w_last_bit;

  assign w_accept   = (r_state == ST_IDLE) && in_valid;
  assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_idx == LAST_IDX);

  // Match counter value after this cycle's detector output, saturating at all-ones.
  always_comb begin
    w_count_step = r_count;
    if (det_y && (r_count != {CW{1'b1}})) begin
      w_count_step = r_count + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef SCAN_CONTINUE_EN
          w_state_next = ST_SHIFT;
`else
          w_state_next = ST_CLEAR;
`endif
        end
      end
      ST_CLEAR:  w_state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_last_bit) begin
          w_state_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Shift register, bit index and match counter; result captured on the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_count     <= '0;
      r_out_count <= '0;
    end else if (w_accept) begin
      r_shift   <= in_data;
      r_bit_idx <= '0;
      r_count   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_shift   <= {r_shift[W-2:0], 1'b0};
      r_bit_idx <= r_bit_idx + 1'b1;
      r_count   <= w_count_step;
      if (w_last_bit) begin
        r_out_count <= w_count_step;
      end
    end
  end

`ifdef SCAN_CONTINUE_EN
  // The detector is never cleared between words.
  assign det_clr = 1'b0;
`else
  logic r_det_clr;

  // Registered clear pulse, high for exactly the CLEAR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_det_clr <= 1'b0;
    end else begin
      r_det_clr <= (w_state_next == ST_CLEAR);
    end
  end

  assign det_clr = r_det_clr;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign det_en    = (r_state == ST_SHIFT);
  assign det_a     = r_shift[W-1];
  assign out_valid = (r_state == ST_REPORT);
  assign out_count = r_out_count;

endmodule

// File: tb/tb_detector_scan_ctrl.sv
// Self-checking bench for detector_scan_ctrl with a behavioural 10110 detector.
// Expected counts come from a plain substring search over the bit stream.
module tb_detector_scan_ctrl;

  localparam int W   = 16;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;
`ifdef SCAN_CONTINUE_EN
  localparam int LAT     = W + 1;
  localparam int EXP_CLR = 0;
`else
  localparam int LAT     = W + 2;
  localparam int EXP_CLR = 1;
`endif
  localparam int THR = LAT + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          det_en;
  logic          det_a;
  logic          det_clr;
  logic          det_y;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          busy;

  always #5 clk = ~clk;

  detector_scan_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .det_en(det_en), .det_a(det_a), .det_clr(det_clr),
    .det_y(det_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .busy(busy)
  );

  // External Mealy detector for 10110 (overlapping), cleared by reset or det_clr.
  logic [3:0] hist;
  always @(posedge clk or posedge reset) begin
    if (reset)       hist <= 4'd0;
    else if (det_clr) hist <= 4'd0;
    else if (det_en)  hist <= {hist[2:0], det_a};
  end
  assign det_y = det_en && ({hist, det_a} == 5'b10110);

  typedef struct {
    int          count;
    int          t_acc;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   prefix[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic void fail(string name);
    n_checks++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endfunction

  // Count occurrences of 10110 that end inside this word; earlier bits only
  // contribute as a prefix when the detector is not cleared between words.
  function automatic int ref_count(logic [15:0] d);
    bit bits[$];
    int pat[5] = '{1, 0, 1, 1, 0};
    int plen;
    int n = 0;
    bits = prefix;
    plen = bits.size();
    for (int i = W - 1; i >= 0; i--) bits.push_back(d[i]);
    for (int s = 0; s + 5 <= bits.size(); s++) begin
      bit hit = 1'b1;
      for (int k = 0; k < 5; k++) if (int'(bits[s+k]) != pat[k]) hit = 1'b0;
      if (hit && (s + 4 >= plen)) n++;
    end
`ifdef SCAN_CONTINUE_EN
    while (bits.size() > 4) void'(bits.pop_front());
    prefix = bits;
`endif
    return (n > SAT) ? SAT : n;
  endfunction

  // Offer one word, wait for acceptance, record the expectation.
  task automatic send(input logic [15:0] d, output int t_acc);
    exp_t e;
    bit ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      fail("send_timeout");
      in_valid = 1'b0;
      t_acc = -1;
      return;
    end
    e.count = ref_count(d);
    e.data  = d;
    e.t_acc = cyc + 1;
    exp_q.push_back(e);
    t_acc = e.t_acc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drain_timeout");
  endtask

  // Monitor: drives out_ready, pops the scoreboard on each result handshake.
  int   en_cnt = 0, clr_cnt = 0, hold_cnt = 0, last_rep = 0, prev_count = 0;
  bit   in_rep = 1'b0, prev_ready = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      en_cnt = 0; clr_cnt = 0; in_rep = 1'b0; last_rep = 0;
    end else begin
      if (det_en)  en_cnt++;
      if (det_clr) clr_cnt++;
      check("in_ready_vs_busy", int'(in_ready), int'(!busy));
      if (out_valid) begin
        check("in_ready_in_report", int'(in_ready), 0);
        if (!in_rep) begin
          in_rep   = 1'b1;
          hold_cnt = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", int'(out_valid), 0);
          end else begin
            // cycle n is the clock period that ends at rising edge n
            check("latency", cyc + 1 - exp_q[0].t_acc, LAT);
            check("det_en_cycles", en_cnt, W);
            check("det_clr_cycles", clr_cnt, EXP_CLR);
          end
          en_cnt = 0; clr_cnt = 0;
        end else if (!prev_ready) begin
          check("out_count_stable", int'(out_count), prev_count);
        end
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = (hold_cnt >= 5);
        endcase
        hold_cnt++;
        if (out_ready) begin
          in_rep   = 1'b0;
          last_rep = int'(out_count);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("count_%h", e.data), int'(out_count), e.count);
          end
        end
        prev_count = int'(out_count);
        prev_ready = out_ready;
      end else begin
        if (in_rep) begin
          check("out_valid_held", int'(out_valid), 1);
          in_rep = 1'b0;
        end
        check("out_count_hold", int'(out_count), last_rep);
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  logic [15:0] pats[6] = '{16'hB000, 16'hB580, 16'h0000, 16'h000B, 16'hB6DB, 16'h2D6C};

  initial begin
    int t0, t1;
    bit ok;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_det_en", int'(det_en), 0);
    check("rst_det_clr", int'(det_clr), 0);
    check("rst_out_count", int'(out_count), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed words back to back with out_ready high: fixed throughput.
    ready_mode = 0;
    send(16'hB000, t0);
    send(16'hB580, t1); check("throughput_1", t1 - t0, THR); t0 = t1;
    send(16'h0000, t1); check("throughput_2", t1 - t0, THR); t0 = t1;
    send(16'h000B, t1); check("throughput_3", t1 - t0, THR); t0 = t1;
    send(16'h0000, t1); check("throughput_4", t1 - t0, THR); t0 = t1;
    send(16'hB6DB, t1); check("throughput_5", t1 - t0, THR);
    drain();

    // Consumer stalls five cycles; the next word waits for IDLE.
    ready_mode = 2;
    send(16'hB000, t0);
    send(16'hB580, t1); check("stall_accept", t1 - t0, THR + 5);
    drain();

    // Reset at SHIFT bit 7 discards the word.
    ready_mode = 0;
    send(16'hB5A5, t0);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (det_en) begin ok = 1'b1; break; end
    end
    if (!ok) fail("wait_shift");
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    prefix.delete();
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_det_en", int'(det_en), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (30) @(negedge clk);
    send(16'hB000, t0);
    drain();

    // Randomised words, gaps and consumer back-pressure.
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [15:0] d;
      if ($urandom_range(0, 2) == 0) d = pats[$urandom_range(0, 5)];
      else d = 16'($urandom);
      send(d, t0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
